// File: rtl/uart_rx_frame_ctrl.sv
// Frame sequencer for the UART receiver: SYNC, LEN, payload, CSUM -> validated payload stream.
// Optional frame statistics counters are enabled with `define UART_RX_FRAME_STATS_EN.
`timescale 1ns/1ps

module uart_rx_frame_ctrl #(
  parameter int         MAX_LEN      = 16,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         TIMEOUT_CLKS = 104160
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_last,
  output logic        frame_ok,
  output logic        frame_err,
  output logic        overrun
`ifdef UART_RX_FRAME_STATS_EN
  ,
  output logic [15:0] ok_count,
  output logic [15:0] err_count
`endif
);

  localparam int TW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CLKS - 1);
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    IDLE,
    GET_LEN,
    GET_DATA,
    GET_CSUM,
    DRAIN
  } state_t;

  state_t        state, state_d;
  logic [7:0]    len, len_d;
  logic [7:0]    csum, csum_d;
  logic [7:0]    wr_ptr, wr_ptr_d;
  logic [7:0]    rd_ptr, rd_ptr_d;
  logic [TW-1:0] tcnt, tcnt_d;
  logic          ok_d, err_d, ovr_d;
  logic          wr_en;
  logic          in_frame;

  logic [7:0] mem [MAX_LEN];

  assign in_frame = (state == GET_LEN) || (state == GET_DATA) || (state == GET_CSUM);

  always_comb begin
    state_d  = state;
    len_d    = len;
    csum_d   = csum;
    wr_ptr_d = wr_ptr;
    rd_ptr_d = rd_ptr;
    tcnt_d   = tcnt;
    ok_d     = 1'b0;
    err_d    = 1'b0;
    ovr_d    = 1'b0;
    wr_en    = 1'b0;

    // Inter-byte watchdog; a byte arriving in the expiry cycle takes priority.
    if (in_frame) begin
      if (rx_valid) begin
        tcnt_d = '0;
      end else if (tcnt == TO_LAST) begin
        err_d   = 1'b1;
        state_d = IDLE;
        tcnt_d  = '0;
      end else begin
        tcnt_d = tcnt + TW'(1);
      end
    end

    case (state)
      IDLE: begin
        if (rx_valid && (rx_byte == SYNC_BYTE)) begin
          state_d = GET_LEN;
          tcnt_d  = '0;
        end
      end
      GET_LEN: begin
        if (rx_valid) begin
          if ((rx_byte == 8'd0) || (rx_byte > MAX_LEN_B)) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            len_d    = rx_byte;
            csum_d   = rx_byte;
            wr_ptr_d = 8'd0;
            state_d  = GET_DATA;
          end
        end
      end
      GET_DATA: begin
        if (rx_valid) begin
          wr_en    = 1'b1;
          csum_d   = csum + rx_byte;
          wr_ptr_d = wr_ptr + 8'd1;
          if (wr_ptr == len - 8'd1) begin
            state_d = GET_CSUM;
          end
        end
      end
      GET_CSUM: begin
        if (rx_valid) begin
          if (rx_byte == csum) begin
            ok_d     = 1'b1;
            rd_ptr_d = 8'd0;
            state_d  = DRAIN;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      DRAIN: begin
        // The receiver cannot be stalled, so bytes arriving now are lost.
        if (rx_valid) begin
          ovr_d = 1'b1;
        end
        if (out_ready) begin
          rd_ptr_d = rd_ptr + 8'd1;
          if (rd_ptr == len - 8'd1) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      len       <= 8'd0;
      csum      <= 8'd0;
      wr_ptr    <= 8'd0;
      rd_ptr    <= 8'd0;
      tcnt      <= '0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_d;
      len       <= len_d;
      csum      <= csum_d;
      wr_ptr    <= wr_ptr_d;
      rd_ptr    <= rd_ptr_d;
      tcnt      <= tcnt_d;
      frame_ok  <= ok_d;
      frame_err <= err_d;
      overrun   <= ovr_d;
    end
  end

  // Payload storage needs no reset; it is only read back after being written.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= rx_byte;
    end
  end

  assign out_valid = (state == DRAIN);
  assign out_data  = (state == DRAIN) ? mem[rd_ptr[AW-1:0]] : 8'h00;
  assign out_last  = (state == DRAIN) && (rd_ptr == len - 8'd1);

`ifdef UART_RX_FRAME_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ok_count  <= 16'd0;
      err_count <= 16'd0;
    end else begin
      if (frame_ok && (ok_count != 16'hFFFF)) begin
        ok_count <= ok_count + 16'd1;
      end
      if (frame_err && (err_count != 16'hFFFF)) begin
        err_count <= err_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Self-checking bench for uart_rx_frame_ctrl: directed vector table, multi-cycle corner
// sequences and randomized frames scored against a frame-level expectation model.
`timescale 1ns/1ps

module tb_uart_rx_frame_ctrl;

  localparam int MAX_LEN = 16;
  localparam int TIMEOUT = 50;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       out_ready = 1'b0;
  logic       out_valid, out_last, frame_ok, frame_err, overrun;
  logic [7:0] out_data;
`ifdef UART_RX_FRAME_STATS_EN
  logic [15:0] ok_count, err_count;
`endif

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [7:0] data;
    logic       last;
  } beat_t;
  typedef struct {
    int         n;
    logic [7:0] b [20];
    int         exp_ok;
    int         exp_err;
    int         exp_beats;
  } vec_t;

  int    checks = 0;
  int    failures = 0;
  int    ok_cnt = 0;
  int    err_cnt = 0;
  int    ovr_cnt = 0;
  int    cyc = 0;
  int    beat_cyc[$];
  beat_t exp_q[$];
  vec_t  tbl[7];
  bit    rand_ready = 1'b0;
  bit    prev_valid = 1'b0;

  always #5 clk = ~clk;

  uart_rx_frame_ctrl #(
    .MAX_LEN(MAX_LEN),
    .SYNC_BYTE(8'hA5),
    .TIMEOUT_CLKS(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx_valid(rx_valid),
    .rx_byte(rx_byte),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_last(out_last),
    .frame_ok(frame_ok),
    .frame_err(frame_err),
    .overrun(overrun)
`ifdef UART_RX_FRAME_STATS_EN
    ,
    .ok_count(ok_count),
    .err_count(err_count)
`endif
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Monitor: counts pulses and scores every handshake against the expected payload queue.
  always @(negedge clk) begin
    beat_t e;
    cyc++;
    if (frame_ok)  ok_cnt++;
    if (frame_err) err_cnt++;
    if (overrun)   ovr_cnt++;
    if (frame_ok || frame_err || overrun)
      checkOutput("pulse_exclusive", int'(frame_ok) + int'(frame_err) + int'(overrun), 1);
    if (frame_ok || (out_valid && !prev_valid))
      checkOutput("valid_with_ok", int'({out_valid, frame_ok}), 3);
    if (out_valid && out_ready) begin
      beat_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_beat", int'(out_data), -1);
      end else begin
        e = exp_q.pop_front();
        checkOutput("out_data", int'(out_data), int'(e.data));
        checkOutput("out_last", int'(out_last), int'(e.last));
      end
    end
    prev_valid = out_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic sendByte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic sendSeq(input bq_t q, input int max_gap);
    foreach (q[i]) begin
      sendByte(q[i]);
      repeat ($urandom_range(0, max_gap)) tick();
    end
  endtask

  task automatic waitIdle();
    int n = 0;
    tick();
    tick();
    while (out_valid && n < 3000) begin
      tick();
      n++;
    end
    if (n >= 3000) checkOutput("drain_timeout", 1, 0);
  endtask

  // Expected beats of a well-formed frame: everything between LEN and CSUM.
  task automatic pushPayload(input bq_t q);
    for (int i = 2; i < q.size() - 1; i++) begin
      beat_t e;
      e.data = q[i];
      e.last = (i == q.size() - 2);
      exp_q.push_back(e);
    end
  endtask

  task automatic loadVec(input int idx, input bq_t q, input int eo, input int ee, input int eb);
    tbl[idx].n = q.size();
    foreach (q[i]) tbl[idx].b[i] = q[i];
    tbl[idx].exp_ok    = eo;
    tbl[idx].exp_err   = ee;
    tbl[idx].exp_beats = eb;
  endtask

  task automatic applyStimulus(input int idx);
    bq_t q;
    int  ok0 = ok_cnt;
    int  err0 = err_cnt;
    int  b0 = beat_cyc.size();
    for (int i = 0; i < tbl[idx].n; i++) q.push_back(tbl[idx].b[i]);
    if (tbl[idx].exp_ok != 0) pushPayload(q);
    sendSeq(q, 0);
    waitIdle();
    checkOutput($sformatf("v%0d_ok", idx), ok_cnt - ok0, tbl[idx].exp_ok);
    checkOutput($sformatf("v%0d_err", idx), err_cnt - err0, tbl[idx].exp_err);
    checkOutput($sformatf("v%0d_beats", idx), beat_cyc.size() - b0, tbl[idx].exp_beats);
    if (tbl[idx].exp_beats > 0)
      checkOutput($sformatf("v%0d_consecutive", idx),
                  beat_cyc[beat_cyc.size() - 1] - beat_cyc[b0], tbl[idx].exp_beats - 1);
    checkOutput($sformatf("v%0d_q_empty", idx), exp_q.size(), 0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_out_valid"}, int'(out_valid), 0);
    checkOutput({tag, "_out_data"},  int'(out_data), 0);
    checkOutput({tag, "_out_last"},  int'(out_last), 0);
    checkOutput({tag, "_frame_ok"},  int'(frame_ok), 0);
    checkOutput({tag, "_frame_err"}, int'(frame_err), 0);
    checkOutput({tag, "_overrun"},   int'(overrun), 0);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog expired");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bq_t        q;
    int         ok0, err0, ovr0, b0, seen, unstable, ok_exp, err_exp;
    logic [7:0] len, s, d;

    q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};  loadVec(0, q, 1, 0, 3);
    q = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h00};         loadVec(1, q, 0, 1, 0);
    q = '{8'hA5, 8'h01, 8'h7F, 8'h80};                loadVec(2, q, 1, 0, 1);
    q = '{8'hA5, 8'h00};                              loadVec(3, q, 0, 1, 0);
    q = '{8'hA5, 8'h11};                              loadVec(4, q, 0, 1, 0);
    q = '{8'hA5, 8'h10};
    for (int i = 1; i <= 16; i++) q.push_back(8'(i));
    q.push_back(8'h98);
    loadVec(5, q, 1, 0, 16);
    q = '{8'h3C, 8'h42};                              loadVec(6, q, 0, 0, 0);

    repeat (3) tick();
    checkAllZero("reset");
    rst_n = 1'b1;
    tick();

    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) applyStimulus(i);

    $display("[TB] timeout sequence");
    err0 = err_cnt;
    q = '{8'hA5, 8'h02, 8'h01};
    sendSeq(q, 0);
    seen = 0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (frame_err && seen == 0) seen = k;
    end
    checkOutput("timeout_latency", seen, TIMEOUT);
    checkOutput("timeout_err_once", err_cnt - err0, 1);
    ok0 = ok_cnt;
    err0 = err_cnt;
    sendByte(8'h02);
    repeat (5) tick();
    checkOutput("idle_ignore_ok", ok_cnt - ok0, 0);
    checkOutput("idle_ignore_err", err_cnt - err0, 0);
    checkOutput("idle_ignore_valid", int'(out_valid), 0);

    $display("[TB] backpressure and overrun sequence");
    out_ready = 1'b0;
    q = '{8'hA5, 8'h02, 8'hAA, 8'hBB, 8'h67};
    pushPayload(q);
    b0 = beat_cyc.size();
    ovr0 = ovr_cnt;
    sendSeq(q, 0);
    unstable = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) sendByte(8'h55);
      else tick();
      if (!(out_valid && out_data == 8'hAA && !out_last)) unstable++;
    end
    checkOutput("hold_stable", unstable, 0);
    checkOutput("overrun_pulse", ovr_cnt - ovr0, 1);
    out_ready = 1'b1;
    waitIdle();
    checkOutput("bp_beats", beat_cyc.size() - b0, 2);
    checkOutput("bp_q_empty", exp_q.size(), 0);
    checkOutput("overrun_once", ovr_cnt - ovr0, 1);

    $display("[TB] async reset sequences");
    q = '{8'hA5, 8'h04, 8'h01, 8'h02};
    sendSeq(q, 0);
    ok0 = ok_cnt;
    err0 = err_cnt;
    #2 rst_n = 1'b0;
    #1 checkAllZero("rst_data");
    tick();
    rst_n = 1'b1;
    repeat (TIMEOUT + 5) tick();
    checkOutput("rst_data_no_ok", ok_cnt - ok0, 0);
    checkOutput("rst_data_no_err", err_cnt - err0, 0);

    out_ready = 1'b0;
    q = '{8'hA5, 8'h01, 8'h7F, 8'h80};
    sendSeq(q, 0);
    tick();
    checkOutput("pre_rst_valid", int'(out_valid), 1);
    ok0 = ok_cnt;
    err0 = err_cnt;
    ovr0 = ovr_cnt;
    #2 rst_n = 1'b0;
    #1 checkAllZero("rst_drain");
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("rst_drain_no_pulses", (ok_cnt - ok0) + (err_cnt - err0) + (ovr_cnt - ovr0), 0);
    out_ready = 1'b1;
    applyStimulus(0);

    $display("[TB] randomized frames");
    rand_ready = 1'b1;
    ok_exp = 0;
    err_exp = 0;
    ok0 = ok_cnt;
    err0 = err_cnt;
    ovr0 = ovr_cnt;
    for (int u = 0; u < 40; u++) begin
      int typ = $urandom_range(0, 9);
      q.delete();
      if (typ <= 6) begin
        len = 8'($urandom_range(1, MAX_LEN));
        q.push_back(8'hA5);
        q.push_back(len);
        s = len;
        for (int i = 0; i < int'(len); i++) begin
          d = 8'($urandom_range(0, 255));
          q.push_back(d);
          s = s + d;
        end
        if (typ <= 4) begin
          q.push_back(s);
          pushPayload(q);
          ok_exp++;
        end else begin
          q.push_back(s ^ 8'($urandom_range(1, 255)));
          err_exp++;
        end
      end else if (typ <= 8) begin
        q.push_back(8'hA5);
        q.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255)));
        err_exp++;
      end else begin
        d = 8'($urandom_range(0, 255));
        q.push_back((d == 8'hA5) ? 8'h5A : d);
      end
      sendSeq(q, 3);
      waitIdle();
    end
    rand_ready = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    checkOutput("rand_ok_count", ok_cnt - ok0, ok_exp);
    checkOutput("rand_err_count", err_cnt - err0, err_exp);
    checkOutput("rand_no_overrun", ovr_cnt - ovr0, 0);
    checkOutput("rand_q_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame_ctrl.md
Name: uart_rx_frame_ctrl

Overview:
- Sequences the byte stream from the UART receiver into validated frames.
- Frame format: SYNC byte, LEN byte, LEN payload bytes, CSUM byte.
- Buffers the payload, checks length and checksum, and guards against inter-byte timeouts.
- Sits between the receiver's dataValid/Bite outputs and the command logic, which consumes frames over a valid/ready stream.

Parameters:
- MAX_LEN, 16: maximum payload bytes. Buffer depth. Range 1..255.
- SYNC_BYTE, 8'hA5: frame start marker.
- TIMEOUT_CLKS, 104160: idle clocks allowed between bytes inside a frame. Default is 20 bit times at 5208 clocks per bit.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rx_valid  in  1  one-cycle pulse from the receiver's dataValid.
- rx_byte  in  8  received byte from the receiver's Bite; sampled only when rx_valid=1.
- out_valid  out  1  payload byte available.
- out_ready  in  1  consumer accepts the byte when out_valid&out_ready.
- out_data  out  8  payload byte.
- out_last  out  1  qualifies the final payload byte of the frame.
- frame_ok  out  1  one-cycle pulse when the checksum matches.
- frame_err  out  1  one-cycle pulse on bad LEN, bad CSUM or timeout.
- overrun  out  1  one-cycle pulse when a byte is dropped during DRAIN.

Behaviour:
- Reset: state=IDLE; all outputs 0; pointers, length, checksum and timeout counter cleared. Buffer contents are don't-care.
- IDLE:
  - rx_valid with rx_byte==SYNC_BYTE -> GET_LEN.
  - Any other byte is ignored silently (no error).
- GET_LEN, on rx_valid:
  - rx_byte==0 or rx_byte>MAX_LEN -> frame_err, go to IDLE.
  - Otherwise store len=rx_byte, set csum=rx_byte, wr_ptr=0, go to GET_DATA.
- GET_DATA, on rx_valid:
  - buf[wr_ptr]<=rx_byte; csum<=csum+rx_byte (mod 256); wr_ptr++.
  - When wr_ptr==len-1 -> GET_CSUM.
- GET_CSUM, on rx_valid:
  - rx_byte==csum -> frame_ok, rd_ptr=0, go to DRAIN.
  - Otherwise frame_err, go to IDLE.
- Timeout:
  - Counter clears on every rx_valid and on entry to GET_LEN.
  - It increments each cycle in GET_LEN, GET_DATA and GET_CSUM.
  - When it reaches TIMEOUT_CLKS-1 with no rx_valid: frame_err, go to IDLE.
  - rx_valid in the same cycle wins over the timeout.
- DRAIN:
  - out_valid=1, out_data=buf[rd_ptr], out_last=(rd_ptr==len-1).
  - On handshake rd_ptr++. Handshake on last -> out_valid falls the next cycle, go to IDLE.
  - out_data and out_last stay stable while out_valid=1 and out_ready=0.
  - rx_valid during DRAIN: byte dropped, overrun pulses the next cycle. This includes a SYNC_BYTE, so a new frame is never started from DRAIN.
- Pulse timing: frame_ok, frame_err and overrun are registered, assert the cycle after the causing rx_valid or timeout, and are never simultaneous.
- Latency:
  - out_valid rises 1 cycle after the CSUM byte's rx_valid, the same cycle as frame_ok.
  - Maximum throughput is 1 byte per clock.
- Widths: pointers and len are 8 bits; the timeout counter is $clog2(TIMEOUT_CLKS) bits.
- Reset mid-frame or mid-drain: immediate return to IDLE; the partial frame is discarded with no pulses.

Optional Feature:
- Macro: UART_RX_FRAME_STATS_EN.
- Defined:
  - Adds outputs ok_count[15:0] and err_count[15:0].
  - Each increments on frame_ok or frame_err respectively, saturating at 16'hFFFF.
  - Both cleared by rst_n.
- Not defined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Good frame: bytes A5,03,11,22,33,69 with out_ready=1 -> frame_ok pulse once; out_data 11,22,33 on consecutive cycles; out_last only with 33.
- Bad checksum: A5,02,10,20,00 -> frame_err pulse; out_valid stays 0; next A5,01,7F,80 -> frame_ok, out_data=7F with out_last=1.
- Length errors: A5,00 and A5,11 (MAX_LEN=16) -> frame_err each; A5,10 plus 16 bytes plus correct csum -> 16 beats, out_last on the 16th.
- Timeout: TIMEOUT_CLKS=50; A5,02,01 then 60 idle cycles -> frame_err exactly 50 clocks after the 01 byte; a later 02 byte is ignored in IDLE.
- Backpressure/overrun: good 2-byte frame with out_ready=0 for 10 cycles, rx_valid byte 55 injected during DRAIN -> out_data held stable; overrun pulses once; both payload bytes delivered after ready rises.
- Async reset: assert rst_n=0 mid-GET_DATA and mid-DRAIN -> all outputs 0 immediately; subsequent good frame decoded correctly.
